// File: rtl/count_pkg.sv
// Shared state encoding and counter widths for the counter-bus monitor.
package count_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, LOCKED, FAULT} mon_state_t;

  localparam int WRAP_CNT_W = 16;
  localparam int ERR_CNT_W  = 8;
endpackage

// File: rtl/sat_counter.sv
// Event counter that holds at all-ones instead of rolling over.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_count <= '0;
    end else if (en && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/count_monitor.sv
// Tracks a free-running counter bus, flags wraps and sequence breaks, and
// latches a fault after ERR_LIMIT back-to-back mismatches.
module count_monitor
  import count_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int STEP      = 1,
  parameter int ERR_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      val,
  input  logic                  val_valid,
  input  logic                  clr,
  output logic                  locked,
  output logic                  fault,
  output logic                  wrap_pulse,
  output logic                  err_pulse,
  output logic [WRAP_CNT_W-1:0] wrap_count,
  output logic [ERR_CNT_W-1:0]  err_count
);

  localparam logic [WIDTH:0] STEP_X    = (WIDTH+1)'(STEP);
  localparam logic [3:0]     LIMIT_M1  = 4'(ERR_LIMIT - 1);

  mon_state_t       r_state;
  mon_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] w_prev_nxt;
  logic [3:0]       r_consec;
  logic [3:0]       w_consec_nxt;
  logic             r_wrap_pulse;
  logic             r_err_pulse;
  logic             w_wrap_nxt;
  logic             w_err_nxt;
  logic [WIDTH:0]   w_sum;
  logic             w_match;
  logic             w_clear;

  // The extra sum bit is the wrap indicator for the expected value.
  assign w_sum   = {1'b0, r_prev} + STEP_X;
  assign w_match = (val == w_sum[WIDTH-1:0]);
  assign w_clear = rst | clr;

  always_comb begin
    w_state_nxt  = r_state;
    w_prev_nxt   = r_prev;
    w_consec_nxt = r_consec;
    w_wrap_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    if (val_valid) begin
      case (r_state)
        IDLE: begin
          w_prev_nxt  = val;
          w_state_nxt = SYNC;
        end
        SYNC: begin
          w_prev_nxt = val;
          if (w_match) w_state_nxt = LOCKED;
        end
        LOCKED: begin
          w_prev_nxt = val;
          if (w_match) begin
            w_consec_nxt = '0;
            w_wrap_nxt   = w_sum[WIDTH];
          end else begin
            w_err_nxt    = 1'b1;
            w_consec_nxt = r_consec + 4'd1;
            if (r_consec >= LIMIT_M1) w_state_nxt = FAULT;
          end
        end
        FAULT: begin
          w_state_nxt = FAULT;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_state      <= IDLE;
      r_prev       <= '0;
      r_consec     <= '0;
      r_wrap_pulse <= 1'b0;
      r_err_pulse  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev       <= w_prev_nxt;
      r_consec     <= w_consec_nxt;
      r_wrap_pulse <= w_wrap_nxt;
      r_err_pulse  <= w_err_nxt;
    end
  end

  sat_counter #(.W(WRAP_CNT_W)) u_wrap_cnt (
    .clk   (clk),
    .clr   (w_clear),
    .en    (w_wrap_nxt),
    .count (wrap_count)
  );

  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk   (clk),
    .clr   (w_clear),
    .en    (w_err_nxt),
    .count (err_count)
  );

  assign locked     = (r_state == LOCKED);
  assign fault      = (r_state == FAULT);
  assign wrap_pulse = r_wrap_pulse;
  assign err_pulse  = r_err_pulse;

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: lock, wrap, error, fault, clear, gaps, saturation.
module tb_count_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  val;
  logic        val_valid;
  logic        clr;
  logic        locked;
  logic        fault;
  logic        wrap_pulse;
  logic        err_pulse;
  logic [15:0] wrap_count;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  count_monitor #(.WIDTH(4), .STEP(1), .ERR_LIMIT(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .val        (val),
    .val_valid  (val_valid),
    .clr        (clr),
    .locked     (locked),
    .fault      (fault),
    .wrap_pulse (wrap_pulse),
    .err_pulse  (err_pulse),
    .wrap_count (wrap_count),
    .err_count  (err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Drive one sample on the falling edge; return 1 ns after the next rising edge.
  task automatic cyc(input logic [3:0] v, input logic vv);
    @(negedge clk);
    val       = v;
    val_valid = vv;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".locked"},     32'(locked),     32'd0);
    chk({tag, ".fault"},      32'(fault),      32'd0);
    chk({tag, ".wrap_pulse"}, 32'(wrap_pulse), 32'd0);
    chk({tag, ".err_pulse"},  32'(err_pulse),  32'd0);
    chk({tag, ".wrap_count"}, 32'(wrap_count), 32'd0);
    chk({tag, ".err_count"},  32'(err_count),  32'd0);
  endtask

  logic [3:0] p;

  initial begin
    rst = 1'b1; clr = 1'b0; val = 4'd0; val_valid = 1'b1;

    // 1: reset then lock on 0,1
    cyc(4'd0, 1'b1);
    chk_all_zero("rst1");
    cyc(4'd5, 1'b1);
    chk_all_zero("rst2");
    @(negedge clk); rst = 1'b0;
    cyc(4'd0, 1'b1);
    chk("t1.locked_after0", 32'(locked), 32'd0);
    cyc(4'd1, 1'b1);
    chk("t1.locked_after1", 32'(locked), 32'd1);
    cyc(4'd2, 1'b1);
    chk("t1.locked_after2", 32'(locked), 32'd1);
    chk("t1.err_pulse", 32'(err_pulse), 32'd0);

    // 2: run to 14, wrap via 15 -> 0
    for (int i = 3; i <= 14; i++) cyc(4'(i), 1'b1);
    chk("t2.wrap_at14", 32'(wrap_pulse), 32'd0);
    cyc(4'd15, 1'b1);
    chk("t2.wrap_at15", 32'(wrap_pulse), 32'd0);
    cyc(4'd0, 1'b1);
    chk("t2.wrap_at0", 32'(wrap_pulse), 32'd1);
    chk("t2.wrap_count0", 32'(wrap_count), 32'd1);
    cyc(4'd1, 1'b1);
    chk("t2.wrap_at1", 32'(wrap_pulse), 32'd0);
    chk("t2.wrap_count1", 32'(wrap_count), 32'd1);
    chk("t2.err_pulse", 32'(err_pulse), 32'd0);
    chk("t2.err_count", 32'(err_count), 32'd0);

    // 3: single injected error, resync on observed value
    for (int i = 2; i <= 5; i++) cyc(4'(i), 1'b1);
    cyc(4'd9, 1'b1);
    chk("t3.err_pulse9", 32'(err_pulse), 32'd1);
    chk("t3.err_count9", 32'(err_count), 32'd1);
    chk("t3.locked9", 32'(locked), 32'd1);
    chk("t3.wrap9", 32'(wrap_pulse), 32'd0);
    cyc(4'd10, 1'b1);
    chk("t3.err_pulse10", 32'(err_pulse), 32'd0);
    chk("t3.locked10", 32'(locked), 32'd1);
    cyc(4'd11, 1'b1);
    chk("t3.err_pulse11", 32'(err_pulse), 32'd0);
    chk("t3.err_count11", 32'(err_count), 32'd1);

    // 4: stuck value -> three consecutive errors -> fault
    cyc(4'd7, 1'b1);
    chk("t4.err1", 32'(err_pulse), 32'd1);
    chk("t4.cnt1", 32'(err_count), 32'd2);
    chk("t4.fault1", 32'(fault), 32'd0);
    cyc(4'd7, 1'b1);
    chk("t4.err2", 32'(err_pulse), 32'd1);
    chk("t4.cnt2", 32'(err_count), 32'd3);
    chk("t4.locked2", 32'(locked), 32'd1);
    cyc(4'd7, 1'b1);
    chk("t4.err3", 32'(err_pulse), 32'd1);
    chk("t4.cnt3", 32'(err_count), 32'd4);
    chk("t4.fault3", 32'(fault), 32'd1);
    chk("t4.locked3", 32'(locked), 32'd0);
    cyc(4'd7, 1'b1);
    cyc(4'd8, 1'b1);
    chk("t4.frozen_err", 32'(err_pulse), 32'd0);
    chk("t4.frozen_cnt", 32'(err_count), 32'd4);
    chk("t4.frozen_fault", 32'(fault), 32'd1);
    chk("t4.frozen_wrapcnt", 32'(wrap_count), 32'd1);

    // 5: soft clear out of fault, relock from IDLE
    @(negedge clk); clr = 1'b1;
    cyc(4'd3, 1'b1);
    chk_all_zero("t5.clr");
    @(negedge clk); clr = 1'b0;
    cyc(4'd3, 1'b1);
    chk("t5.locked3", 32'(locked), 32'd0);
    cyc(4'd4, 1'b1);
    chk("t5.locked4", 32'(locked), 32'd1);

    // 6: gaps in val_valid are ignored
    @(negedge clk); clr = 1'b1;
    cyc(4'd0, 1'b0);
    @(negedge clk); clr = 1'b0;
    cyc(4'd2, 1'b1);
    cyc(4'd9, 1'b0);
    chk("t6.gap_locked", 32'(locked), 32'd0);
    chk("t6.gap_err", 32'(err_pulse), 32'd0);
    cyc(4'd3, 1'b1);
    chk("t6.locked3", 32'(locked), 32'd1);
    cyc(4'd12, 1'b0);
    chk("t6.gap2_err", 32'(err_pulse), 32'd0);
    cyc(4'd4, 1'b1);
    chk("t6.locked4", 32'(locked), 32'd1);
    chk("t6.err_count", 32'(err_count), 32'd0);

    // Alternate mismatch/match so errors never reach three in a row.
    p = 4'd4;
    for (int i = 0; i < 300; i++) begin
      p = p + 4'd5;
      cyc(p, 1'b1);
      p = p + 4'd1;
      cyc(p, 1'b1);
      if (i == 99) chk("t6.err_count100", 32'(err_count), 32'd100);
    end
    chk("t6.err_sat", 32'(err_count), 32'd255);
    chk("t6.sat_locked", 32'(locked), 32'd1);
    chk("t6.sat_fault", 32'(fault), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
